// File: rtl/lbp_pkg.sv
// Shared types and helpers for the parametrised LBP engine.
// Holds the FSM state enum, neighbour bit positions and the per-neighbour compare rule.
package lbp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BORDER,
        S_LOAD9,
        S_CALC,
        S_WRITE,
        S_LOAD3,
        S_DONE
    } state_t;

    localparam int unsigned NB_TL = 0;
    localparam int unsigned NB_T  = 1;
    localparam int unsigned NB_TR = 2;
    localparam int unsigned NB_L  = 3;
    localparam int unsigned NB_R  = 4;
    localparam int unsigned NB_BL = 5;
    localparam int unsigned NB_B  = 6;
    localparam int unsigned NB_BR = 7;

    // Sum is one bit wider than the operands, so a centre+thr beyond the pixel range
    // can never be reached by a neighbour and the bit reads 0.
    function automatic logic lbp_bit(input logic [31:0] neigh,
                                     input logic [31:0] centre,
                                     input logic [31:0] thr);
        logic [32:0] w_sum;
        w_sum = {1'b0, centre} + {1'b0, thr};
        return ({1'b0, neigh} >= w_sum);
    endfunction

endpackage

// File: rtl/lbp_window3x3.sv
// 3x3 pixel window: raster-indexed loads, left shift by one column, and the 8-bit LBP compare.
// Index 4 is the centre; indices 2/5/8 form the right column refilled after a shift.
module lbp_window3x3
    import lbp_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [3:0]       i_load_idx,
    input  logic [PIX_W-1:0] i_load_data,
    input  logic             i_shift,
    input  logic [PIX_W-1:0] i_thr,
    output logic [7:0]       o_code
);

    logic [PIX_W-1:0] r_win [9];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 9; i++) r_win[i] <= '0;
        end else if (i_shift) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
        end else if (i_load) begin
            r_win[i_load_idx] <= i_load_data;
        end
    end

    always_comb begin
        o_code        = '0;
        o_code[NB_TL] = lbp_bit(32'(r_win[0]), 32'(r_win[4]), 32'(i_thr));
        o_code[NB_T]  = lbp_bit(32'(r_win[1]), 32'(r_win[4]), 32'(i_thr));
        o_code[NB_TR] = lbp_bit(32'(r_win[2]), 32'(r_win[4]), 32'(i_thr));
        o_code[NB_L]  = lbp_bit(32'(r_win[3]), 32'(r_win[4]), 32'(i_thr));
        o_code[NB_R]  = lbp_bit(32'(r_win[5]), 32'(r_win[4]), 32'(i_thr));
        o_code[NB_BL] = lbp_bit(32'(r_win[6]), 32'(r_win[4]), 32'(i_thr));
        o_code[NB_B]  = lbp_bit(32'(r_win[7]), 32'(r_win[4]), 32'(i_thr));
        o_code[NB_BR] = lbp_bit(32'(r_win[8]), 32'(r_win[4]), 32'(i_thr));
    end

endmodule

// File: rtl/lbp_engine_param.sv
// Parametrised LBP engine: optional border fill, then a raster pass over interior pixels
// reading a 3x3 window (9 reads at row start, 3 per step) and writing one code per pixel.
module lbp_engine_param
    import lbp_pkg::*;
#(
    parameter int unsigned IMG_W        = 128,
    parameter int unsigned IMG_H        = 128,
    parameter int unsigned PIX_W        = 8,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned WRITE_BORDER = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PIX_W-1:0]  thr,
    input  logic [7:0]        border_val,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [PIX_W-1:0]  gray_data,
    output logic              lbp_valid,
    input  logic              lbp_ready,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              busy,
    output logic              finish
);

    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] WM1_A    = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] WM2_A    = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] HM2_A    = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] HM3_A    = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] FIRST_C  = ADDR_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'((IMG_H - 1) * IMG_W);

    state_t            r_state, w_state_nx;
    logic [PIX_W-1:0]  r_thr;
    logic [7:0]        r_bval, r_code, w_code;
    logic [ADDR_W-1:0] r_x, r_y, r_caddr, r_gaddr, r_baddr, r_bcnt;
    logic [1:0]        r_bphase;
    logic [3:0]        r_cnt, w_load_idx;
    logic              w_idle, w_last_col, w_last_pix, w_border_end;

    assign w_idle       = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_last_col   = (r_x == WM2_A);
    assign w_last_pix   = w_last_col && (r_y == HM2_A);
    assign w_border_end = (r_bphase == 2'd3) && (r_bcnt == HM3_A);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: if (start) w_state_nx = (WRITE_BORDER != 0) ? S_BORDER : S_LOAD9;
            S_BORDER:       if (lbp_ready && w_border_end) w_state_nx = S_LOAD9;
            S_LOAD9:        if (r_cnt == 4'd8) w_state_nx = S_CALC;
            S_LOAD3:        if (r_cnt == 4'd2) w_state_nx = S_CALC;
            S_CALC:         w_state_nx = S_WRITE;
            S_WRITE: begin
                if (lbp_ready) begin
                    if (w_last_pix)      w_state_nx = S_DONE;
                    else if (w_last_col) w_state_nx = S_LOAD9;
                    else                 w_state_nx = S_LOAD3;
                end
            end
            default:        w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_idx = r_cnt;
        if (r_state == S_LOAD3)
            w_load_idx = (r_cnt == 4'd0) ? 4'd2 : ((r_cnt == 4'd1) ? 4'd5 : 4'd8);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_thr    <= '0;
            r_bval   <= '0;
            r_code   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_caddr  <= '0;
            r_gaddr  <= '0;
            r_baddr  <= '0;
            r_bcnt   <= '0;
            r_bphase <= '0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_thr    <= thr;
                        r_bval   <= border_val;
                        r_x      <= ADDR_W'(1);
                        r_y      <= ADDR_W'(1);
                        r_caddr  <= FIRST_C;
                        r_gaddr  <= '0;
                        r_cnt    <= '0;
                        r_baddr  <= '0;
                        r_bcnt   <= '0;
                        r_bphase <= '0;
                    end
                end
                S_BORDER: begin
                    if (lbp_ready) begin
                        r_bcnt <= r_bcnt + ADDR_W'(1);
                        unique case (r_bphase)
                            2'd0: if (r_bcnt == WM1_A) begin
                                r_bphase <= 2'd1; r_bcnt <= '0; r_baddr <= LAST_ROW;
                            end else r_baddr <= r_baddr + ADDR_W'(1);
                            2'd1: if (r_bcnt == WM1_A) begin
                                r_bphase <= 2'd2; r_bcnt <= '0; r_baddr <= W_A;
                            end else r_baddr <= r_baddr + ADDR_W'(1);
                            2'd2: if (r_bcnt == HM3_A) begin
                                r_bphase <= 2'd3; r_bcnt <= '0; r_baddr <= W_A + WM1_A;
                            end else r_baddr <= r_baddr + W_A;
                            default: if (!w_border_end) r_baddr <= r_baddr + W_A;
                        endcase
                    end
                end
                S_LOAD9: begin
                    r_cnt   <= r_cnt + 4'd1;
                    r_gaddr <= ((r_cnt == 4'd2) || (r_cnt == 4'd5)) ? r_gaddr + WM2_A
                                                                     : r_gaddr + ADDR_W'(1);
                end
                S_LOAD3: begin
                    r_cnt   <= r_cnt + 4'd1;
                    r_gaddr <= r_gaddr + W_A;
                end
                S_CALC: begin
                    r_code <= w_code;
                    r_cnt  <= '0;
                end
                S_WRITE: begin
                    if (lbp_ready) begin
                        // New centre minus (W+1) for a row start, or minus (W-1) for the next right column: both are caddr+2-W.
                        r_gaddr <= r_caddr + ADDR_W'(2) - W_A;
                        r_cnt   <= '0;
                        if (w_last_col) begin
                            r_x     <= ADDR_W'(1);
                            r_y     <= r_y + ADDR_W'(1);
                            r_caddr <= r_caddr + ADDR_W'(3);
                        end else begin
                            r_x     <= r_x + ADDR_W'(1);
                            r_caddr <= r_caddr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    lbp_window3x3 #(
        .PIX_W (PIX_W)
    ) u_win (
        .clk         (clk),
        .reset       (reset),
        .i_load      (gray_req),
        .i_load_idx  (w_load_idx),
        .i_load_data (gray_data),
        .i_shift     ((r_state == S_WRITE) && lbp_ready),
        .i_thr       (r_thr),
        .o_code      (w_code)
    );

    assign gray_req  = (r_state == S_LOAD9) || (r_state == S_LOAD3);
    assign gray_addr = r_gaddr;
    assign lbp_valid = (r_state == S_WRITE) || (r_state == S_BORDER);
    assign lbp_addr  = (r_state == S_BORDER) ? r_baddr : ((r_state == S_WRITE) ? r_caddr : '0);
    assign lbp_data  = (r_state == S_BORDER) ? r_bval : r_code;
    assign busy      = !w_idle;
    assign finish    = (r_state == S_DONE);

endmodule

// File: tb/tb_lbp_engine_param.sv
// Scoreboard bench for lbp_engine_param on 4x4 images: one instance without and one with border fill.
module tb_lbp_engine_param;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b, ready;
    logic [7:0] thr, bval;
    logic [7:0] mem [16];

    logic       gra, va, busy_a, fin_a;
    logic [3:0] gaa, la;
    logic [7:0] gda, da;
    logic       grb, vb, busy_b, fin_b;
    logic [3:0] gab, lb;
    logic [7:0] gdb, db;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   rnd_en = 1'b0;
    bit   prev_stall = 1'b0;
    logic [3:0] prev_addr;
    logic [7:0] prev_data;

    always #5 clk = ~clk;

    assign gda = mem[gaa];
    assign gdb = mem[gab];

    lbp_engine_param #(
        .IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4), .WRITE_BORDER(0)
    ) u_dut (
        .clk(clk), .reset(rst_n), .start(start_a), .thr(thr), .border_val(bval),
        .gray_req(gra), .gray_addr(gaa), .gray_data(gda),
        .lbp_valid(va), .lbp_ready(ready), .lbp_addr(la), .lbp_data(da),
        .busy(busy_a), .finish(fin_a)
    );

    lbp_engine_param #(
        .IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4), .WRITE_BORDER(1)
    ) u_dutb (
        .clk(clk), .reset(rst_n), .start(start_b), .thr(thr), .border_val(bval),
        .gray_req(grb), .gray_addr(gab), .gray_data(gdb),
        .lbp_valid(vb), .lbp_ready(ready), .lbp_addr(lb), .lbp_data(db),
        .busy(busy_b), .finish(fin_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string who, input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL write_%s: got addr %0d data %0h expected no write", who, a, d);
        end else begin
            e = q.pop_front();
            if (a !== e.addr || d !== e.data) begin
                n_fail++;
                $display("FAIL write_%s: got addr %0d data %0h expected addr %0d data %0h",
                         who, a, d, e.addr, e.data);
            end
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic push4(input logic [7:0] c5, input logic [7:0] c6,
                         input logic [7:0] c9, input logic [7:0] c10);
        push(4'd5, c5); push(4'd6, c6); push(4'd9, c9); push(4'd10, c10);
    endtask

    task automatic push_border(input logic [7:0] bv);
        logic [3:0] ba [12];
        ba = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd12, 4'd13, 4'd14, 4'd15, 4'd4, 4'd8, 4'd7, 4'd11};
        for (int i = 0; i < 12; i++) push(ba[i], bv);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    endtask

    task automatic set_const(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic set_irreg();
        logic [7:0] img [16];
        img = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd25, 8'd33, 8'd60,
                8'd5,  8'd35, 8'd25, 8'd70, 8'd80, 8'd12, 8'd90, 8'd25};
        for (int i = 0; i < 16; i++) mem[i] = img[i];
    endtask

    // exp_first / exp_done are cycle numbers counted with cycle 1 right after the start edge; 0 skips the check.
    task automatic run_frame(input bit use_b, input logic [7:0] t, input logic [7:0] bv,
                             input int exp_first, input int exp_done);
        int n;
        int first;
        bit done;
        thr  = t;
        bval = bv;
        @(posedge clk); #1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk("busy_after_start", use_b ? busy_b : busy_a, 1);
        n = 1; first = -1; done = 1'b0;
        while (!done && n < 3000) begin
            if (first < 0 && (use_b ? vb : va)) first = n;
            if (use_b ? fin_b : fin_a) done = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("finish_reached", done, 1);
        if (exp_first > 0) chk("first_write_cycle", first, exp_first);
        if (exp_done > 0)  chk("done_cycle", n, exp_done);
        chk("busy_at_done", use_b ? busy_b : busy_a, 0);
        chk("scoreboard_drained", q.size(), 0);
    endtask

    initial begin : ready_drv
        ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ready = rnd_en ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (va && ready) sb_check("a", la, da);
                if (vb && ready) sb_check("b", lb, db);
                if (prev_stall && va) begin
                    n_cmp++;
                    if (la !== prev_addr || da !== prev_data) begin
                        n_fail++;
                        $display("FAIL stall_stable: got addr %0d data %0h expected addr %0d data %0h",
                                 la, da, prev_addr, prev_data);
                    end
                end
                if (va && !ready) chk("gray_req_in_stall", gra, 0);
                prev_stall = va && !ready;
                prev_addr  = la;
                prev_data  = da;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; thr = '0; bval = '0;
        set_ramp();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gray_req", gra, 0);
        chk("rst_lbp_valid", va, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_finish", fin_a, 0);
        chk("rst_gray_addr", gaa, 0);
        chk("rst_lbp_addr", la, 0);
        chk("rst_lbp_data", da, 0);
        rst_n = 1'b1;

        push4(8'hF0, 8'hF0, 8'hF0, 8'hF0);
        run_frame(1'b0, 8'd0, 8'd0, 11, 33);

        push4(8'hE0, 8'hE0, 8'hE0, 8'hE0);
        run_frame(1'b0, 8'd3, 8'd0, 11, 33);

        set_irreg();
        push4(8'hDC, 8'hB4, 8'hA1, 8'hDF);
        run_frame(1'b0, 8'd0, 8'd0, 11, 33);

        push4(8'h48, 8'h90, 8'hA1, 8'h5C);
        run_frame(1'b0, 8'd10, 8'd0, 11, 33);

        set_const(8'h80);
        push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_frame(1'b0, 8'd0, 8'd0, 11, 33);

        push4(8'h00, 8'h00, 8'h00, 8'h00);
        run_frame(1'b0, 8'h80, 8'd0, 11, 33);

        set_ramp();
        push_border(8'hAA);
        push4(8'hF0, 8'hF0, 8'hF0, 8'hF0);
        run_frame(1'b1, 8'd0, 8'hAA, 1, 45);

        set_irreg();
        rnd_en = 1'b1;
        push4(8'hDC, 8'hB4, 8'hA1, 8'hDF);
        run_frame(1'b0, 8'd0, 8'd0, 0, 0);
        push_border(8'h5A);
        push4(8'hDC, 8'hB4, 8'hA1, 8'hDF);
        run_frame(1'b1, 8'd0, 8'h5A, 0, 0);
        rnd_en = 1'b0;

        // Abort inside the second row's LOAD3 (cycles 28-30), then a clean frame.
        set_ramp();
        push4(8'hF0, 8'hF0, 8'hF0, 8'hF0);
        thr = 8'd0;
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 1;
        while (n < 29) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_reset_gray_req", gra, 1);
        chk("pre_reset_writes_left", q.size(), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_gray_req", gra, 0);
        chk("abort_lbp_valid", va, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_gray_addr", gaa, 0);
        chk("abort_lbp_addr", la, 0);
        chk("abort_lbp_data", da, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push4(8'hF0, 8'hF0, 8'hF0, 8'hF0);
        run_frame(1'b0, 8'd0, 8'd0, 11, 33);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
